dynamic_priority_requester: RTL and testbench
=============================================

# dynamic_priority_requester

Requester-side companion of the dynamic-priority round-robin arbiter. It accepts per-client request pulses and queues them as per-client pending counts. It drives the arbiter's `req`/`prt` bus and consumes its `grant`/`valid` result. Waiting clients are aged toward higher priority (lower `prt` value) so that no client starves. It sits between the client request sources and the arbiter and returns a one-cycle acknowledge per granted request.

## Interface
- `N`, 4: number of clients.
- `LN`, `$clog2(N)`: width of priority and grant index.
- `DEPTH`, 4: max pending requests per client; must be ≥ 1.
- `AGE_PERIOD`, 8: `clk_en` cycles of waiting per one-step priority promotion; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clk_en` in 1: state advances only on cycles where `clk_en`=1.
- `new_req` in N: per-client request pulse, sampled when `clk_en`=1.
- `base_prt` in `[LN-1:0] [N-1:0]`: per-client base priority; 0 is highest.
- `grant` in LN: arbiter winner index.
- `valid` in 1: `grant` is meaningful.
- `req` out N: per-client pending flag to the arbiter.
- `prt` out `[LN-1:0] [N-1:0]`: per-client current priority to the arbiter.
- `ack` out N: one-cycle pulse when a client's request is consumed.
- `overflow` out N: one-cycle pulse when a `new_req` is dropped because the count is full.

## Operation
- Per-client state:
  - pending count `cnt[i]`, range 0..`DEPTH`.
  - priority register `prt[i]`.
  - age counter `age[i]`, range 0..`AGE_PERIOD-1`.
- `req[i]` = (`cnt[i]` != 0), registered.
- Grant consumption, when `clk_en`=1: a grant is taken when `valid`=1 and `req[grant]`=1.
  - `ack[grant]` pulses next cycle.
  - `cnt[grant]` decrements.
  - `prt[grant]` reloads `base_prt[grant]`.
  - `age[grant]` clears.
- Grant to a client with `req`=0: ignored. No ack, no state change.
- New request when `cnt[i]` < `DEPTH`: increments `cnt[i]`.
- New request when `cnt[i]` = `DEPTH` and the same client is not granted this cycle: request dropped, `overflow[i]` pulses.
- Simultaneous `new_req[i]` and grant of client i: `cnt[i]` is unchanged and `ack[i]` pulses. No overflow, even when the count is full.
- Idle client (`cnt[i]`=0): `prt[i]` loads `base_prt[i]` every `clk_en` cycle, and `age[i]` is held at 0.
- Aging, for each pending, non-granted client:
  - `age[i]` increments each `clk_en` cycle.
  - When `age[i]`=`AGE_PERIOD-1`, `age[i]` wraps to 0 and `prt[i]` decrements, saturating at 0.
- Clients are independent; all N update in parallel in the same cycle.

## Timing
- Reset values: `req`=0, `ack`=0, `overflow`=0, all `cnt`=0, all `age`=0, all `prt`=N-1.
- The first `clk_en` cycle after reset loads `base_prt` into `prt`.
- `new_req` in cycle t (with `clk_en`) → `req` high in cycle t+1.
- Grant in cycle t → `ack` in cycle t+1.
  - `req` drops in t+1 if `cnt` reaches 0.
  - Otherwise `prt` shows `base_prt` in t+1.
- When `clk_en`=0:
  - all registers hold, including `ack` and `overflow`.
  - `new_req`, `grant` and `valid` are ignored.
- Reset mid-operation: all pending requests are discarded with no ack. Outputs take their reset values in the cycle after `rst` is sampled high.
- No combinational path from any input to any output.

## Configuration
- `DPR_AGING_EN` defined: aging is active as described above.
- `DPR_AGING_EN` not defined:
  - age counters are not built.
  - `prt[i]` equals the registered `base_prt[i]`, updated every `clk_en` cycle whether or not the client is pending.
  - All other behaviour is unchanged.

## Test plan
- Reset: assert `rst` with `clk_en`=1.
  - Next cycle: `req`=0, `ack`=0, `overflow`=0, `prt`=3 for N=4.
  - One cycle later: `prt`=`base_prt`.
- Basic round trip: `new_req`=4'b0010 at t, `valid`=1 and `grant`=1 at t+1.
  - `req`=4'b0010 at t+1.
  - `ack`=4'b0010 at t+2 and `req`=0 at t+2.
- Overflow: 5 consecutive `new_req[0]` pulses, no grants, `DEPTH`=4.
  - `cnt[0]`=4.
  - `overflow[0]` pulses exactly once, in the cycle after the 5th pulse.
- Full plus simultaneous grant: `cnt[0]`=4, then `new_req[0]` and grant 0 in the same cycle.
  - `ack[0]`=1, no overflow, `cnt[0]` stays 4.
- Aging (`DPR_AGING_EN` defined, `AGE_PERIOD`=8): `base_prt[2]`=3, pending with no grant.
  - `prt[2]` steps 3→2→1→0, one step every 8 `clk_en` cycles, then stays at 0.
  - A grant reloads 3 and clears the age counter.
- `clk_en` gating: hold `clk_en`=0 for 5 cycles while pulsing `new_req` and grants.
  - No change to `req`, `prt`, `cnt`, or `age`.
  - `ack` and `overflow` hold their values.

Source files
------------

// File: rtl/dynamic_priority_requester.sv
// Requester-side front end for the dynamic-priority round-robin arbiter: queues per-client
// requests, drives req/prt, consumes grant/valid. Define DPR_AGING_EN to build priority aging.
module dynamic_priority_requester #(
    parameter int unsigned N          = 4,
    parameter int unsigned LN         = $clog2(N),
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AGE_PERIOD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [N-1:0]      new_req,
    input  logic [LN-1:0]     base_prt [N-1:0],
    input  logic [LN-1:0]     grant,
    input  logic              valid,
    output logic [N-1:0]      req,
    output logic [LN-1:0]     prt [N-1:0],
    output logic [N-1:0]      ack,
    output logic [N-1:0]      overflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] cnt_q      [N-1:0];
    logic [CW-1:0] cnt_d      [N-1:0];
    logic [LN-1:0] prt_d      [N-1:0];
    logic [N-1:0]  req_d;
    logic [N-1:0]  ack_d;
    logic [N-1:0]  overflow_d;
    logic [N-1:0]  take;
    logic [N-1:0]  full;

`ifdef DPR_AGING_EN
    localparam int unsigned AW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

    logic [AW-1:0] age_q [N-1:0];
    logic [AW-1:0] age_d [N-1:0];
`endif

    // Next-state for every client; everything holds when clk_en is low.
    always_comb begin
        cnt_d      = cnt_q;
        prt_d      = prt;
        req_d      = req;
        ack_d      = ack;
        overflow_d = overflow;
        take       = '0;
        full       = '0;
`ifdef DPR_AGING_EN
        age_d      = age_q;
`endif
        if (clk_en) begin
            for (int i = 0; i < int'(N); i++) begin
                take[i]       = valid && (grant == LN'(i)) && req[i];
                full[i]       = (cnt_q[i] == CW'(DEPTH));
                ack_d[i]      = take[i];
                overflow_d[i] = new_req[i] && !take[i] && full[i];

                // A grant and a new request in the same cycle cancel out.
                if (take[i] && !new_req[i]) begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end else if (!take[i] && new_req[i] && !full[i]) begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
                req_d[i] = (cnt_d[i] != '0);

`ifdef DPR_AGING_EN
                if (!req[i] || take[i]) begin
                    prt_d[i] = base_prt[i];
                    age_d[i] = '0;
                end else if (age_q[i] == AW'(AGE_PERIOD - 1)) begin
                    age_d[i] = '0;
                    if (prt[i] != '0) begin
                        prt_d[i] = prt[i] - LN'(1);
                    end
                end else begin
                    age_d[i] = age_q[i] + AW'(1);
                end
`else
                prt_d[i] = base_prt[i];
`endif
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req      <= '0;
            ack      <= '0;
            overflow <= '0;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= '0;
                prt[i]   <= LN'(N - 1);
`ifdef DPR_AGING_EN
                age_q[i] <= '0;
`endif
            end
        end else begin
            req      <= req_d;
            ack      <= ack_d;
            overflow <= overflow_d;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= cnt_d[i];
                prt[i]   <= prt_d[i];
`ifdef DPR_AGING_EN
                age_q[i] <= age_d[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_dynamic_priority_requester.sv
// Self-checking bench for dynamic_priority_requester: directed steps then random traffic,
// compared every cycle against a per-client queue/priority model.
module tb_dynamic_priority_requester;

    localparam int N          = 4;
    localparam int LN         = 2;
    localparam int DEPTH      = 4;
    localparam int AGE_PERIOD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic [N-1:0]  new_req;
    logic [LN-1:0] base_prt [N-1:0];
    logic [LN-1:0] grant;
    logic          valid;
    logic [N-1:0]  req;
    logic [LN-1:0] prt [N-1:0];
    logic [N-1:0]  ack;
    logic [N-1:0]  overflow;

    int            m_cnt  [N];
    int            m_prt  [N];
    int            m_wait [N];
    logic [N-1:0]  m_ack;
    logic [N-1:0]  m_ovf;
    int            errors = 0;
    int            checks = 0;

    dynamic_priority_requester #(
        .N(N), .LN(LN), .DEPTH(DEPTH), .AGE_PERIOD(AGE_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .new_req(new_req),
        .base_prt(base_prt), .grant(grant), .valid(valid),
        .req(req), .prt(prt), .ack(ack), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input logic r, input logic e, input logic [N-1:0] nr,
                        input logic v, input logic [LN-1:0] g);
        logic [N-1:0] exp_req;
        bit           tk;
        rst = r; clk_en = e; new_req = nr; valid = v; grant = g;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0; m_prt[i] = N - 1; m_wait[i] = 0;
            end
            m_ack = '0; m_ovf = '0;
        end else if (e) begin
            for (int i = 0; i < N; i++) begin
                tk       = v && (int'(g) == i) && (m_cnt[i] > 0);
                m_ack[i] = tk;
                m_ovf[i] = nr[i] && !tk && (m_cnt[i] == DEPTH);
`ifdef DPR_AGING_EN
                if (m_cnt[i] == 0 || tk) begin
                    m_prt[i]  = int'(base_prt[i]);
                    m_wait[i] = 0;
                end else begin
                    m_wait[i]++;
                    if (m_wait[i] % AGE_PERIOD == 0 && m_prt[i] > 0) m_prt[i]--;
                end
`else
                m_prt[i] = int'(base_prt[i]);
`endif
                if (tk && !nr[i]) m_cnt[i]--;
                else if (!tk && nr[i] && m_cnt[i] < DEPTH) m_cnt[i]++;
            end
        end
        #1;
        for (int i = 0; i < N; i++) exp_req[i] = (m_cnt[i] > 0);
        check("req", 32'(req), 32'(exp_req));
        check("ack", 32'(ack), 32'(m_ack));
        check("overflow", 32'(overflow), 32'(m_ovf));
        for (int i = 0; i < N; i++) check($sformatf("prt%0d", i), 32'(prt[i]), 32'(m_prt[i]));
    endtask

    initial begin
        base_prt[0] = 2'd1; base_prt[1] = 2'd2; base_prt[2] = 2'd3; base_prt[3] = 2'd0;

        // Reset, then base priorities load on the first enabled cycle.
        step(1'b1, 1'b1, 4'b0000, 1'b0, 2'd0);
        check("rst_prt2", 32'(prt[2]), 32'd3);
        check("rst_prt3", 32'(prt[3]), 32'd3);
        step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
        check("load_prt3", 32'(prt[3]), 32'd0);

        // Basic round trip on client 1.
        step(1'b0, 1'b1, 4'b0010, 1'b0, 2'd0);
        check("rt_req", 32'(req), 32'h2);
        step(1'b0, 1'b1, 4'b0000, 1'b1, 2'd1);
        check("rt_ack", 32'(ack), 32'h2);
        check("rt_req_drop", 32'(req), 32'h0);

        // Grant to an idle client is ignored.
        step(1'b0, 1'b1, 4'b0000, 1'b1, 2'd3);
        check("idle_grant_ack", 32'(ack), 32'h0);

        // Overflow on the fifth pulse into a depth-4 queue.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 4'b0001, 1'b0, 2'd0);
        check("ovf_pulse", 32'(overflow), 32'h1);
        step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
        check("ovf_once", 32'(overflow), 32'h0);

        // Full queue with simultaneous request and grant: ack, no overflow, count stays 4.
        step(1'b0, 1'b1, 4'b0001, 1'b1, 2'd0);
        check("full_grant_ack", 32'(ack), 32'h1);
        check("full_grant_ovf", 32'(overflow), 32'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'b0000, 1'b1, 2'd0);
        check("drain_req", 32'(req), 32'h0);

        // Aging of client 2 while pending, then reload on grant.
        step(1'b0, 1'b1, 4'b0100, 1'b0, 2'd0);
        step(1'b0, 1'b1, 4'b0100, 1'b0, 2'd0);
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
`ifdef DPR_AGING_EN
        check("aged_prt2", 32'(prt[2]), 32'd0);
`else
        check("aged_prt2", 32'(prt[2]), 32'd3);
`endif
        step(1'b0, 1'b1, 4'b0000, 1'b1, 2'd2);
        check("reload_prt2", 32'(prt[2]), 32'd3);
        check("reload_req", 32'(req), 32'h4);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);

        // Gating: ack from the grant below must hold through disabled cycles.
        step(1'b0, 1'b1, 4'b1000, 1'b1, 2'd2);
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, N'($urandom_range(0, 15)), 1'b1, LN'($urandom_range(0, 3)));
        check("gate_ack_hold", 32'(ack), 32'h4);

        // Random traffic with occasional resets and priority changes.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0)
                base_prt[$urandom_range(0, N - 1)] = LN'($urandom_range(0, 3));
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
                 N'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0), LN'($urandom_range(0, 3)));
        end

        // Reset mid-operation discards pending work.
        step(1'b0, 1'b1, 4'b1111, 1'b0, 2'd0);
        step(1'b1, 1'b1, 4'b1111, 1'b1, 2'd0);
        check("midrst_req", 32'(req), 32'h0);
        step(1'b0, 1'b1, 4'b0000, 1'b1, 2'd0);
        check("midrst_ack", 32'(ack), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
